// File: rtl/tag_cmp_rr.sv
// Multi-port tag-compare front end: arbitrates requesters onto shared way SRAMs
// (fixed priority or round-robin) and compares the winner's late tag one cycle later.
module tag_cmp_rr #(
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned WAYS       = 8,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 44,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned BE_WIDTH   = 16,
    parameter int unsigned RR_MODE    = 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      clear_i,
    input  logic [NR_PORTS*WAYS-1:0]                  req_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]            addr_i,
    input  logic [NR_PORTS*LINE_WIDTH-1:0]            wdata_i,
    input  logic [NR_PORTS-1:0]                       we_i,
    input  logic [NR_PORTS*BE_WIDTH-1:0]              be_i,
    input  logic [NR_PORTS*TAG_WIDTH-1:0]             tag_i,
    output logic [NR_PORTS-1:0]                       gnt_o,
    output logic [WAYS-1:0]                           req_o,
    output logic [ADDR_WIDTH-1:0]                     addr_o,
    output logic [LINE_WIDTH-1:0]                     wdata_o,
    output logic                                      we_o,
    output logic [BE_WIDTH-1:0]                       be_o,
    input  logic                                      sram_ready_i,
    input  logic [WAYS*TAG_WIDTH-1:0]                 tag_rdata_i,
    input  logic [WAYS-1:0]                           valid_rdata_i,
    input  logic [WAYS*LINE_WIDTH-1:0]                rdata_i,
    output logic [WAYS*LINE_WIDTH-1:0]                rdata_o,
    output logic                                      rsp_valid_o,
    output logic [NR_PORTS-1:0]                       rsp_port_o,
    output logic [WAYS-1:0]                           hit_way_o,
    output logic                                      hit_o,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] hit_idx_o,
    output logic                                      multi_hit_o,
    output logic                                      err_o
);

    localparam int unsigned RRW  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned IDXW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [RRW-1:0]      rr_q, rr_d;
    logic [NR_PORTS-1:0] id_q;
    logic                vld_q;
    logic [WAYS-1:0]     mask_q;
    logic                we_q;
    logic                err_q;

    logic [NR_PORTS-1:0] active;
    logic [RRW-1:0]      win;
    logic                found;
    logic [TAG_WIDTH-1:0] sel_tag;
    logic                rsp_ok;

    always_comb begin
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            active[p] = |req_i[p*WAYS +: WAYS];
        end
    end

    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (!rst_i && sram_ready_i) begin
            if (RR_MODE == 0) begin
                for (int unsigned p = 0; p < NR_PORTS; p++) begin
                    if (!found && active[p]) begin
                        found = 1'b1;
                        win   = RRW'(p);
                    end
                end
            end else begin
                for (int unsigned i = 0; i < NR_PORTS; i++) begin
                    idx = (int'(rr_q) + i) % NR_PORTS;
                    if (!found && active[idx]) begin
                        found = 1'b1;
                        win   = RRW'(idx);
                    end
                end
            end
        end
    end

    // Winner mux is one-hot gated so an idle cycle drives all-zero SRAM signals.
    always_comb begin
        gnt_o   = '0;
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (found && (win == RRW'(p))) begin
                gnt_o[p] = 1'b1;
                req_o    = req_i[p*WAYS +: WAYS];
                addr_o   = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_o  = wdata_i[p*LINE_WIDTH +: LINE_WIDTH];
                we_o     = we_i[p];
                be_o     = be_i[p*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (RR_MODE != 0 && found) begin
            rr_d = (win == RRW'(NR_PORTS - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rr_q   <= '0;
            id_q   <= '0;
            vld_q  <= 1'b0;
            mask_q <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            id_q   <= gnt_o;
            vld_q  <= |gnt_o;
            mask_q <= req_o;
            we_q   <= we_o;
            err_q  <= err_q | multi_hit_o;
        end
    end

    assign rdata_o = rdata_i;
    assign rsp_ok  = vld_q & ~we_q & ~rst_i;

    always_comb begin
        sel_tag = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (id_q[p]) begin
                sel_tag = sel_tag | tag_i[p*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_comb begin
        int unsigned cnt;
        cnt       = 0;
        hit_way_o = '0;
        hit_idx_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit_way_o[w] = rsp_ok & mask_q[w] & valid_rdata_i[w] &
                           (tag_rdata_i[w*TAG_WIDTH +: TAG_WIDTH] == sel_tag);
            if (hit_way_o[w]) begin
                cnt = cnt + 1;
            end
        end
        // Descending scan so the lowest hitting way is the last one written.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (hit_way_o[w]) begin
                hit_idx_o = IDXW'(w);
            end
        end
        multi_hit_o = (cnt > 1);
    end

    assign hit_o       = |hit_way_o;
    assign rsp_valid_o = rsp_ok;
    assign rsp_port_o  = rsp_ok ? id_q : '0;
    assign err_o       = ~rst_i & (err_q | multi_hit_o);

endmodule

// File: doc/tag_cmp_rr.md
# tag_cmp_rr

Parametrised successor to the data-cache tag-compare front end. Arbitrates up to NR_PORTS requesters onto one shared set of tag/data SRAM ways, selectable fixed-priority or round-robin, with SRAM back-pressure. Tag compare is performed one cycle after grant against the winning port's late-arriving tag and produces hit vector, encoded hit way, port id and a sticky multi-hit error. Sits between the cache controller ports (miss handler, load/store units) and the way SRAMs.

## Interface
- NR_PORTS, 3: number of requesting ports (≥1)
- WAYS, 8: set associativity (≥1)
- ADDR_WIDTH, 64: SRAM index/offset address width
- TAG_WIDTH, 44: tag width
- LINE_WIDTH, 128: data line width
- BE_WIDTH, 16: byte-enable width (LINE_WIDTH/8)
- RR_MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- clear_i  in  1  synchronous flush of pipeline, pointer and error state
- req_i  in  NR_PORTS×WAYS  per-port way-enable mask; port active if mask non-zero
- addr_i  in  NR_PORTS×ADDR_WIDTH  per-port address
- wdata_i  in  NR_PORTS×LINE_WIDTH  per-port write data
- we_i  in  NR_PORTS  per-port write enable
- be_i  in  NR_PORTS×BE_WIDTH  per-port byte enables
- tag_i  in  NR_PORTS×TAG_WIDTH  per-port tag, valid one cycle after grant
- gnt_o  out  NR_PORTS  one-hot (or zero) grant
- req_o  out  WAYS  way enables to SRAM
- addr_o / wdata_o / we_o / be_o  out  as above  muxed winner signals to SRAM
- sram_ready_i  in  1  SRAM accepts a request this cycle
- tag_rdata_i  in  WAYS×TAG_WIDTH  stored tags (one cycle after request)
- valid_rdata_i  in  WAYS  stored valid bits
- rdata_i  in  WAYS×LINE_WIDTH  stored lines; rdata_o  out  same  pass-through
- rsp_valid_o  out  1  compare result valid
- rsp_port_o  out  NR_PORTS  one-hot port owning the response
- hit_way_o  out  WAYS  per-way hit
- hit_o  out  1  any hit
- hit_idx_o  out  $clog2(WAYS) (min 1)  index of lowest hitting way
- multi_hit_o  out  1  more than one way hit (this cycle)
- err_o  out  1  sticky multi-hit flag

## Operation
- Arbitration (combinational): candidate set = ports with |req_i[p]. No grant when sram_ready_i=0, rst_i=1, or set empty; then gnt_o=0 and req_o/addr_o/wdata_o/we_o/be_o=0.
- Fixed mode: lowest active index wins.
- RR mode: search starts at rr_q, wraps modulo NR_PORTS; first active port wins. On grant to p, rr_q ← (p+1) mod NR_PORTS (p=NR_PORTS-1 wraps to 0). No grant → rr_q holds. NR_PORTS=1 → rr_q constant 0.
- Winner's signals are muxed to SRAM outputs; gnt_o has exactly the winner bit set.
- Stage-1 registers on every cycle: id_q ← gnt_o, vld_q ← |gnt_o, mask_q ← req_o, we_q ← winner we.
- Compare: sel_tag = tag_i[port in id_q] (0 if id_q=0). hit_way_o[w] = vld_q & ~we_q & mask_q[w] & valid_rdata_i[w] & (tag_rdata_i[w]==sel_tag).
- rsp_valid_o = vld_q & ~we_q; rsp_port_o = id_q when rsp_valid_o else 0. Writes produce no response.
- hit_o = |hit_way_o; hit_idx_o = lowest set bit index, 0 if none; multi_hit_o = popcount(hit_way_o)>1.
- err_o set on any cycle with multi_hit_o=1; cleared only by rst_i or clear_i.

## Timing
- Reset (rst_i=1 at edge): rr_q=0, id_q=0, vld_q=0, mask_q=0, we_q=0, err_q=0. During rst_i all outputs are 0 except rdata_o (pass-through).
- clear_i: same register effect as reset, but combinational grant in that cycle is unaffected; the response of a grant issued in the clear cycle is dropped (vld_q=0 next cycle).
- rst_i mid-operation: in-flight response discarded; following cycle rsp_valid_o=0.
- Latency: grant in cycle N → rsp_valid_o/hit outputs in cycle N+1; tag_i and SRAM read data sampled combinationally in N+1.
- Full throughput: one grant and one response per cycle, back-to-back.
- sram_ready_i low in N: no grant, rr_q unchanged, no response in N+1.
- Requests are not held by the block; ungranted ports must keep requesting.

## Test plan
- Fixed mode, req_i ports 0 and 2 active every cycle → gnt_o=001 every cycle; port 2 never granted.
- RR mode, NR_PORTS=3, all active for 6 cycles → gnt_o sequence 001,010,100,001,010,100; rsp_port_o same sequence lagging one cycle.
- RR with port 1 only, then ports 0,1,2 → after grant to 1, rr_q=2, next grant 100, then 001.
- Read, tag 0x1A on port 0, way 3 stores 0x1A valid, mask=0xFF → next cycle rsp_valid_o=1, hit_way_o=0x08, hit_idx_o=3, hit_o=1; same with valid_rdata_i[3]=0 → hit_o=0.
- Ways 2 and 5 match → multi_hit_o=1, hit_idx_o=2, err_o=1 sticky until clear_i pulse, then 0.
- Write grant (we_i=1) → no response next cycle; sram_ready_i=0 with requests → gnt_o=0, rr_q held; rst_i mid-stream → all outputs 0, rsp_valid_o=0 following cycle.
